zom_slot_alloc: RTL
===================

ZOM_SLOT_ALLOC -- requirements
Module: zom_slot_alloc

Interface
REQ-001 Parameter N_SLOTS, default 10: number of zombie slots, range 2..32.
REQ-002 Parameter PEND_W, default 3: pending-request counter width; maximum pending count is 2^PEND_W-1.
REQ-003 Parameter COOLDOWN, default 4: minimum idle cycles between consecutive grants; 0 allowed.
REQ-004 Parameter RSV_TIMEOUT, default 3: cycles a granted slot stays reserved while its ZomLive bit is low.
REQ-005 MAX10_CLK1_50  input  1  single system clock; all state changes on its rising edge.
REQ-006 Reset_n  input  1  asynchronous, active-low reset.
REQ-007 Generate  input  1  spawn request; one request is counted per cycle high.
REQ-008 ZomLive  input  N_SLOTS  bit i high means slot i is occupied.
REQ-009 GenerateOut  output  N_SLOTS  one-hot, one-cycle grant pulse to the chosen slot.
REQ-010 GrantIdx  output  $clog2(N_SLOTS)  index of the slot in GenerateOut; valid only while GenerateOut is nonzero.
REQ-011 Pending  output  PEND_W  current count of unserved requests.
REQ-012 Full  output  1  high when no slot is available, meaning every slot is live or reserved.
REQ-013 Dropped  output  1  one-cycle pulse when a request is lost to saturation.

Function
REQ-014 Slot i is available when ZomLive[i]=0 and its reserved bit rsv[i]=0.
REQ-015 Demand in a cycle is Pending plus Generate (0 or 1).
REQ-016 The FSM has two states, IDLE and COOL.
REQ-017 In IDLE, when demand>0 and at least one slot is available:
- one grant is issued;
- GenerateOut and GrantIdx are registered and appear in the following cycle for exactly one cycle.
REQ-018 Latency: with Generate high at edge k, Pending=0, state IDLE and a free slot, GenerateOut is high during cycle k+1.
REQ-019 Slot selection without the Configuration macro is the lowest available index.
REQ-020 Pending update at each edge is: Pending + Generate - grant.
- Simultaneous request and grant leaves Pending unchanged.
REQ-021 When Generate=1, Pending is at maximum and no grant is issued:
- Pending holds;
- Dropped pulses the next cycle.
REQ-022 On a grant:
- rsv[idx] is set;
- the per-slot timer is loaded with RSV_TIMEOUT.
REQ-023 rsv[i] clears on the first cycle ZomLive[i]=1 is sampled, or when its timer reaches 0, whichever comes first.
REQ-024 On a grant with COOLDOWN>0:
- the FSM enters COOL;
- the counter is loaded with COOLDOWN;
- the FSM returns to IDLE when the counter reaches 0, so the next grant comes no earlier than COOLDOWN+1 cycles later.
REQ-025 On a grant with COOLDOWN=0, the FSM stays in IDLE and may grant every cycle.
REQ-026 No grant is issued in COOL.
- Requests arriving in COOL still accumulate into Pending.
REQ-027 When demand>0 and no slot is available, no grant is issued and Pending is retained.
REQ-028 Full is registered, reflecting the availability mask of the previous cycle.
REQ-029 At most one bit of GenerateOut is high in any cycle.

Reset
REQ-030 Reset_n low asynchronously forces:
- GenerateOut=0, GrantIdx=0, Pending=0, Dropped=0, Full=0;
- rsv=0, all timers=0, cooldown counter=0, round-robin pointer=0, state IDLE.
REQ-031 Reset asserted mid-cooldown or mid-reservation discards all pending requests and reservations.
REQ-032 Operation resumes on the first rising edge after Reset_n deasserts.

Configuration
REQ-033 Macro ZOM_ROUND_ROBIN_EN defined: selection is the first available slot at or above the pointer, wrapping from N_SLOTS-1 to 0.
- The pointer updates to granted index+1 (mod N_SLOTS) on each grant.
REQ-034 Macro absent: fixed lowest-index priority.
- No pointer register is instantiated.

Structure
REQ-035 Package zom_pkg holds:
- the state enum typedef zom_alloc_state_t (IDLE, COOL);
- default parameter constants ZOM_N_SLOTS_DEF, ZOM_PEND_W_DEF, ZOM_COOLDOWN_DEF.
REQ-036 The combinational picker is the sub-module zom_pick:
- inputs: availability mask and pointer;
- outputs: one-hot grant, index and a valid flag.

Verification
REQ-037 N=10, COOLDOWN=0, ZomLive=0, one Generate pulse -> GenerateOut=10'b0000000001 the next cycle, Pending stays 0.
REQ-038 ZomLive=10'b0000011111, Generate pulse -> GenerateOut=10'b0000100000, GrantIdx=5.
REQ-039 COOLDOWN=4, Generate high for 3 consecutive cycles -> grants at cycles 1, 6 and 11; Pending peaks at 2.
REQ-040 ZomLive all ones, Generate high 8 cycles with PEND_W=3:
- Pending saturates at 7;
- Dropped pulses once;
- on clearing ZomLive[3], a grant goes to slot 3.
REQ-041 Grant to slot 2 with ZomLive[2] never rising, RSV_TIMEOUT=3 -> slot 2 is not re-granted for 3 cycles, then becomes eligible again.
REQ-042 With ZOM_ROUND_ROBIN_EN, ZomLive=0, COOLDOWN=0, Generate held -> grants go to slots 0,1,2,...,9,0 in order; Reset_n pulsed mid-sequence -> the next grant is to slot 0.

Source files
------------

// File: rtl/zom_pkg.sv
// zom_pkg: shared state type and default parameters for the zombie slot allocator
package zom_pkg;
  typedef enum logic {IDLE, COOL} zom_alloc_state_t;
  localparam int ZOM_N_SLOTS_DEF     = 10;
  localparam int ZOM_PEND_W_DEF      = 3;
  localparam int ZOM_COOLDOWN_DEF    = 4;
  localparam int ZOM_RSV_TIMEOUT_DEF = 3;
endpackage

// File: rtl/zom_slot_alloc_if.sv
// zom_slot_alloc_if: request/grant bundle between a spawner and the slot allocator
//   Generate    spawn request, one counted per cycle high
//   ZomLive     per-slot occupancy
//   GenerateOut one-hot grant pulse
//   GrantIdx    index of the granted slot
//   Pending     unserved request count
//   Full        no slot available last cycle
//   Dropped     request lost to saturation
interface zom_slot_alloc_if
  import zom_pkg::*;
#(
  parameter int N_SLOTS = ZOM_N_SLOTS_DEF,
  parameter int PEND_W  = ZOM_PEND_W_DEF
);
  logic                       Generate;
  logic [N_SLOTS-1:0]         ZomLive;
  logic [N_SLOTS-1:0]         GenerateOut;
  logic [$clog2(N_SLOTS)-1:0] GrantIdx;
  logic [PEND_W-1:0]          Pending;
  logic                       Full;
  logic                       Dropped;
  modport master (
    output Generate, ZomLive,
    input  GenerateOut, GrantIdx, Pending, Full, Dropped
  );
  modport slave (
    input  Generate, ZomLive,
    output GenerateOut, GrantIdx, Pending, Full, Dropped
  );
endinterface

// File: rtl/zom_pick.sv
// zom_pick: picks the first available slot at or above ptr_i, wrapping around
//   avail_i  availability mask
//   ptr_i    search start index (tied to 0 for fixed lowest-index priority)
//   gnt_o    one-hot selected slot
//   idx_o    index of the selected slot
//   vld_o    a slot was found
module zom_pick
  import zom_pkg::*;
#(
  parameter int N_SLOTS = ZOM_N_SLOTS_DEF,
  localparam int IW = $clog2(N_SLOTS)
) (
  input  logic [N_SLOTS-1:0] avail_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [N_SLOTS-1:0] gnt_o,
  output logic [IW-1:0]      idx_o,
  output logic               vld_o
);
  int j;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j = 0;
    for (int k = 0; k < N_SLOTS; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N_SLOTS) j = j - N_SLOTS;
      if (!vld_o && avail_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o = IW'(j);
        vld_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/zom_slot_alloc.sv
// zom_slot_alloc: grants spawn requests to free zombie slots with cooldown and reservation
//   MAX10_CLK1_50  system clock
//   Reset_n        asynchronous active-low reset
//   bus            zom_slot_alloc_if slave: Generate/ZomLive in,
//                  GenerateOut/GrantIdx/Pending/Full/Dropped out
// Optional: define ZOM_ROUND_ROBIN_EN for round-robin slot selection
// (default is fixed lowest-index priority).
module zom_slot_alloc
  import zom_pkg::*;
#(
  parameter int N_SLOTS     = ZOM_N_SLOTS_DEF,
  parameter int PEND_W      = ZOM_PEND_W_DEF,
  parameter int COOLDOWN    = ZOM_COOLDOWN_DEF,
  parameter int RSV_TIMEOUT = ZOM_RSV_TIMEOUT_DEF
) (
  input logic            MAX10_CLK1_50,
  input logic            Reset_n,
  zom_slot_alloc_if.slave bus
);
  localparam int IW = $clog2(N_SLOTS);
  localparam int TW = $clog2(RSV_TIMEOUT + 2);
  localparam int CW = $clog2(COOLDOWN + 2);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  zom_alloc_state_t   state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_SLOTS-1:0] gout_q, gout_d, rsv_q, rsv_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic               full_q, full_d, drop_q, drop_d;
  logic [TW-1:0]      tmr_q [N_SLOTS];
  logic [TW-1:0]      tmr_d [N_SLOTS];
  logic [N_SLOTS-1:0] avail, pick_gnt;
  logic [IW-1:0]      pick_idx, ptr;
  logic               pick_vld, grant;

  assign avail = ~bus.ZomLive & ~rsv_q;
  assign grant = (state_q == IDLE) && (bus.Generate || pend_q != '0) && pick_vld;

  zom_pick #(.N_SLOTS(N_SLOTS)) u_pick (
    .avail_i(avail),
    .ptr_i  (ptr),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .vld_o  (pick_vld)
  );

`ifdef ZOM_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q;
  always_ff @(posedge MAX10_CLK1_50 or negedge Reset_n) begin
    if (!Reset_n) ptr_q <= '0;
    else if (grant) ptr_q <= (pick_idx == IW'(N_SLOTS - 1)) ? '0 : pick_idx + 1'b1;
  end
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == COOL) begin
      cnt_d = cnt_q - 1'b1;
      state_d = (cnt_q <= CW'(1)) ? IDLE : COOL;
    end else if (grant && COOLDOWN > 0) begin
      cnt_d = CW'(COOLDOWN);
      state_d = COOL;
    end
    pend_d = pend_q;
    drop_d = 1'b0;
    // a grant without a new request can only happen with pend_q > 0
    if (grant && !bus.Generate) begin
      pend_d = pend_q - 1'b1;
    end else if (!grant && bus.Generate) begin
      drop_d = (pend_q == PEND_MAX);
      pend_d = (pend_q == PEND_MAX) ? pend_q : pend_q + 1'b1;
    end
    rsv_d = '0;
    // a reservation lasts RSV_TIMEOUT cycles unless the slot goes live first
    for (int i = 0; i < N_SLOTS; i++) begin
      rsv_d[i] = rsv_q[i] && (tmr_q[i] > TW'(1)) && !bus.ZomLive[i];
      tmr_d[i] = rsv_d[i] ? tmr_q[i] - 1'b1 : '0;
      if (grant && pick_gnt[i]) begin
        rsv_d[i] = (RSV_TIMEOUT > 0);
        tmr_d[i] = TW'(RSV_TIMEOUT);
      end
    end
    gout_d = grant ? pick_gnt : '0;
    gidx_d = grant ? pick_idx : '0;
    full_d = ~|avail;
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pend_q <= '0;
      drop_q <= 1'b0;
      rsv_q <= '0;
      tmr_q <= '{default: '0};
      gout_q <= '0;
      gidx_q <= '0;
      full_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      drop_q <= drop_d;
      rsv_q <= rsv_d;
      tmr_q <= tmr_d;
      gout_q <= gout_d;
      gidx_q <= gidx_d;
      full_q <= full_d;
    end
  end

  assign bus.GenerateOut = gout_q;
  assign bus.GrantIdx = gidx_q;
  assign bus.Pending = pend_q;
  assign bus.Full = full_q;
  assign bus.Dropped = drop_q;
endmodule
